// File: rtl/clock_ctrl_pkg.sv
// Shared types, field indices and default parameter values for the clock field controller.
package clock_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_e;

    localparam int FIELD_MS  = 0;
    localparam int FIELD_SEC = 1;
    localparam int FIELD_MIN = 2;
    localparam int FIELD_HR  = 3;

    localparam int DEF_N_FIELDS      = 4;
    localparam int DEF_TICK_DIV      = 1;
    localparam int DEF_REPEAT_DELAY  = 50;
    localparam int DEF_REPEAT_PERIOD = 10;
    localparam int DEF_BLINK_HALF    = 25;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_field_ctrl_btn_repeat.sv
// Up/down code edge detector with delayed auto-repeat; a clear suppresses pulses until the
// code changes again, so a held button never repeats onto a newly selected field.
module btn_repeat
    import clock_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic [1:0] i_code,
    output logic       o_up,
    output logic       o_down
);

    localparam int CW = clog2_min1((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    r_code_q;
    logic [CW-1:0] r_cnt;
    logic          r_armed;
    logic          r_period;

    logic          w_change;
    logic          w_single;
    logic          w_hit;
    logic          w_fire;
    logic [CW-1:0] w_limit;

    // Pulse decode: fresh code change fires at once, armed single-direction code fires on count.
    always_comb begin
        w_change = (i_code != r_code_q);
        w_single = i_code[1] ^ i_code[0];
        if (r_period) begin
            w_limit = PERIOD_LAST;
        end else begin
            w_limit = DELAY_LAST;
        end
        w_hit  = r_armed & ~w_change & (r_cnt == w_limit);
        w_fire = ~i_clr & (w_change | w_hit);
        o_up   = w_fire & i_code[1];
        o_down = w_fire & i_code[0];
    end

    // Code history and repeat counter; the code register tracks even while cleared.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_code_q <= 2'b00;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_period <= 1'b0;
        end else begin
            r_code_q <= i_code;
            if (i_clr || w_change) begin
                r_armed  <= ~i_clr & w_single;
                r_cnt    <= '0;
                r_period <= 1'b0;
            end else if (w_hit) begin
                r_cnt    <= '0;
                r_period <= 1'b1;
            end else if (r_armed) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_field_ctrl.sv
// Run/set controller for an N-field time counter chain: RUN forwards the prescaled tick and
// carries, SET lets the user pick a field and step it with auto-repeat while the display blinks.
module clock_field_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int N_FIELDS      = DEF_N_FIELDS,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int BLINK_HALF    = DEF_BLINK_HALF,
    localparam int SEL_W        = clog2_min1(N_FIELDS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_set,
    input  logic                i_up,
    input  logic                i_down,
    input  logic                i_left,
    input  logic                i_right,
    input  logic [N_FIELDS-1:0] i_carry,
    output logic [N_FIELDS-1:0] o_up,
    output logic [N_FIELDS-1:0] o_down,
    output logic [SEL_W-1:0]    o_sel,
    output logic                o_setting,
    output logic                o_blink
);

    localparam int PW = clog2_min1(TICK_DIV);
    localparam int BW = clog2_min1(BLINK_HALF);
    localparam logic [PW-1:0]    PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [SEL_W-1:0] SEL_FIRST  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_FIELDS - 1);
    localparam logic             MOVABLE    = (N_FIELDS > 2);

    state_e           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [PW-1:0]    r_pre_cnt;
    logic [BW-1:0]    r_blink_cnt;
    logic             r_blink;
    logic             r_left_q;
    logic             r_right_q;

    state_e           w_state_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_set_active;
    logic             w_left_rise;
    logic             w_right_rise;
    logic             w_move_l;
    logic             w_move_r;
    logic             w_tick;
    logic             w_rep_clr;
    logic             w_rep_up;
    logic             w_rep_dn;
    logic             w_unused_carry;

    assign w_unused_carry = i_carry[N_FIELDS-1];

    // Next mode, selection moves and the repeat clear.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (i_set) begin
                    w_state_nxt = ST_SET;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SET: begin
                if (!i_set) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_SET;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        w_set_active = (r_state == ST_SET) & i_set;
        w_left_rise  = i_left & ~r_left_q;
        w_right_rise = i_right & ~r_right_q;
        w_move_l     = MOVABLE & w_set_active & w_left_rise & ~w_right_rise;
        w_move_r     = MOVABLE & w_set_active & w_right_rise & ~w_left_rise;
        w_rep_clr    = ~w_set_active | w_move_l | w_move_r;
        w_tick       = (r_state == ST_RUN) & (r_pre_cnt == PRE_LAST);

        if (w_state_nxt != r_state) begin
            w_sel_nxt = SEL_FIRST;
        end else if (w_move_l) begin
            w_sel_nxt = (r_sel == SEL_LAST) ? SEL_FIRST : r_sel + SEL_W'(1);
        end else if (w_move_r) begin
            w_sel_nxt = (r_sel == SEL_FIRST) ? SEL_LAST : r_sel - SEL_W'(1);
        end else begin
            w_sel_nxt = r_sel;
        end
    end

    // Mode, selection, button history, prescaler and blink timing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_sel       <= SEL_FIRST;
            r_pre_cnt   <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_left_q    <= 1'b0;
            r_right_q   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_left_q  <= i_left;
            r_right_q <= i_right;
            if (r_state == ST_RUN) begin
                r_pre_cnt   <= (r_pre_cnt == PRE_LAST) ? '0 : r_pre_cnt + PW'(1);
                r_blink_cnt <= '0;
                r_blink     <= i_set;
            end else begin
                r_pre_cnt <= '0;
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

    btn_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_btn_repeat (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_rep_clr),
        .i_code ({i_up, i_down}),
        .o_up   (w_rep_up),
        .o_down (w_rep_dn)
    );

    // Output decode; reset gates everything to zero without waiting for a clock.
    always_comb begin
        o_up      = '0;
        o_down    = '0;
        o_sel     = '0;
        o_setting = 1'b0;
        o_blink   = 1'b0;
        if (i_rst) begin
            o_up = '0;
        end else if (r_state == ST_RUN) begin
            o_up[0]            = w_tick;
            o_up[N_FIELDS-1:1] = i_carry[N_FIELDS-2:0];
        end else begin
            o_setting = 1'b1;
            o_sel     = r_sel;
            o_blink   = r_blink;
            if (i_set) begin
                o_down[0] = 1'b1;
                for (int k = 1; k < N_FIELDS; k++) begin
                    o_up[k]   = (r_sel == SEL_W'(k)) & w_rep_up;
                    o_down[k] = (r_sel == SEL_W'(k)) & w_rep_dn;
                end
            end else begin
                o_down = '0;
            end
        end
    end

endmodule

// File: tb/tb_clock_field_ctrl.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs into a queue and a
// negedge monitor pops and compares against the DUT.
module tb_clock_field_ctrl;

    localparam int N      = 4;
    localparam int TDIV   = 3;
    localparam int RDELAY = 5;
    localparam int RPER   = 2;
    localparam int BHALF  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         set_i = 1'b0, up_i = 1'b0, dn_i = 1'b0, left_i = 1'b0, right_i = 1'b0;
    logic [N-1:0] carry_i = '0;
    logic [N-1:0] o_up, o_down;
    logic [1:0]   o_sel;
    logic         o_setting, o_blink;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    logic [11:0] exp_q[$];

    // model state
    bit         m_set;
    int         m_sel, m_run_cnt, m_set_cnt, m_age;
    bit         m_pl, m_pr;
    logic [1:0] m_pcode;

    clock_field_ctrl #(
        .N_FIELDS(N), .TICK_DIV(TDIV), .REPEAT_DELAY(RDELAY),
        .REPEAT_PERIOD(RPER), .BLINK_HALF(BHALF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_set(set_i), .i_up(up_i), .i_down(dn_i),
        .i_left(left_i), .i_right(right_i), .i_carry(carry_i),
        .o_up(o_up), .o_down(o_down), .o_sel(o_sel), .o_setting(o_setting), .o_blink(o_blink)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // c = {rst, set, up, down, left, right}
    task automatic step(input logic [5:0] c, input logic [N-1:0] carry);
        logic [N-1:0] eu, ed;
        int           es;
        bit           est, ebl, act, lr, rr, mv;
        logic [1:0]   code;
        @(posedge clk);
        #1;
        {rst, set_i, up_i, dn_i, left_i, right_i} = c;
        carry_i = carry;
        eu = '0; ed = '0; es = 0; est = 1'b0; ebl = 1'b0;
        if (c[5]) begin
            m_set = 1'b0; m_sel = 1; m_run_cnt = 0; m_set_cnt = 0; m_age = -1;
            m_pl = 1'b0; m_pr = 1'b0; m_pcode = 2'b00;
        end else begin
            code = c[3:2];
            act  = m_set && c[4];
            lr   = c[1] && !m_pl;
            rr   = c[0] && !m_pr;
            mv   = act && (lr != rr);
            if (!m_set) begin
                eu[0] = ((m_run_cnt + 1) % TDIV) == 0;
                for (int k = 1; k < N; k++) eu[k] = carry[k-1];
            end else begin
                est = 1'b1;
                es  = m_sel;
                ebl = ((m_set_cnt / BHALF) % 2) == 0;
            end
            if (!act || mv) begin
                m_age = -1;
            end else if (code != m_pcode) begin
                m_age = (code == 2'b10 || code == 2'b01) ? 0 : -1;
                eu[m_sel] = code[1];
                ed[m_sel] = code[0];
            end else if (m_age >= 0) begin
                m_age++;
                if (m_age >= RDELAY && ((m_age - RDELAY) % RPER) == 0) begin
                    eu[m_sel] = code[1];
                    ed[m_sel] = code[0];
                end
            end
            if (act) ed[0] = 1'b1;
            if (m_set) begin m_set_cnt++; m_run_cnt = 0; end
            else begin m_run_cnt++; m_set_cnt = 0; end
            if (mv) m_sel = lr ? ((m_sel == N-1) ? 1 : m_sel + 1) : ((m_sel == 1) ? N-1 : m_sel - 1);
            if (m_set != c[4]) begin
                m_set = c[4]; m_sel = 1; m_set_cnt = 0; m_run_cnt = 0;
            end
            m_pl = c[1]; m_pr = c[0]; m_pcode = code;
        end
        exp_q.push_back({eu, ed, 2'(es), est, ebl});
    endtask

    // Monitor: every cycle presents one output vector.
    always @(negedge clk) begin
        logic [11:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {o_up, o_down, o_sel, o_setting, o_blink};
            n_cmp++;
            if (g !== e) begin
                n_mis++;
                $display("FAIL outputs cycle %0d: got {up,dn,sel,setting,blink}=%b_%b_%b_%b_%b required %b_%b_%b_%b_%b",
                         cyc, g[11:8], g[7:4], g[3:2], g[1], g[0], e[11:8], e[7:4], e[3:2], e[1], e[0]);
            end
        end
        cyc++;
    end

    initial begin
        bit s, u, d, l, r, rs;
        int wait_cnt;
        m_set = 1'b0; m_sel = 1; m_run_cnt = 0; m_set_cnt = 0; m_age = -1;
        m_pl = 1'b0; m_pr = 1'b0; m_pcode = 2'b00;

        // reset with junk inputs, then RUN tick/carry
        repeat (3) step({1'b1, 5'($urandom)}, 4'($urandom));
        repeat (12) step(6'b000000, 4'b0000);
        step(6'b000000, 4'b0010);
        repeat (20) step(6'b000000, 4'($urandom));
        // enter SET, carries ignored, blink
        repeat (10) step(6'b010000, 4'b0111);
        // selection moves
        repeat (3) begin step(6'b010010, 4'b0000); step(6'b010000, 4'b0000); end
        repeat (10) step(6'b010001, 4'b0000);
        step(6'b010000, 4'b0000);
        step(6'b010011, 4'b0000);
        step(6'b010000, 4'b0000);
        repeat (2) begin step(6'b010010, 4'b0000); step(6'b010000, 4'b0000); end
        // auto-repeat on up, then simultaneous up&down
        repeat (12) step(6'b011000, 4'b0000);
        step(6'b010000, 4'b0000);
        repeat (8) step(6'b011100, 4'b0000);
        step(6'b010000, 4'b0000);
        // reset mid-repeat, button held across release
        repeat (7) step(6'b010100, 4'b0000);
        repeat (2) step(6'b110100, 4'b0000);
        repeat (6) step(6'b010100, 4'b0000);
        step(6'b010000, 4'b0000);
        repeat (8) step(6'b010100, 4'b0000);
        repeat (3) step(6'b000000, 4'b0000);

        // randomized slowly-changing buttons
        s = 1'b0; u = 1'b0; d = 1'b0; l = 1'b0; r = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 39) == 0) s = ~s;
            if ($urandom_range(0, 5) == 0) u = ~u;
            if ($urandom_range(0, 7) == 0) d = ~d;
            if ($urandom_range(0, 5) == 0) l = ~l;
            if ($urandom_range(0, 5) == 0) r = ~r;
            rs = ($urandom_range(0, 249) == 0);
            step({rs, s, u, d, l, r}, 4'($urandom));
        end

        @(negedge clk);
        #1;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 5) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
